// File: rtl/window_pkg.sv
// Purpose : shared constants and helpers for the 5x5 window generator.
// Latency : n/a (package only).
// Backpressure: n/a.
package window_pkg;

    localparam int WIN_DIM   = 5;  // window is WIN_DIM x WIN_DIM pixels
    localparam int WIN_LINES = 4;  // previous lines held in line buffers

    // Bits needed to hold 0..value-1 (at least 1 bit).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/window_line_buf.sv
// Purpose : one IMG_W x DSIZE line buffer, combinational read, write on accept.
// Latency : read is combinational; write lands on the next rising edge.
// Backpressure: none; a write happens whenever wr_en is high.
// Ports   : clock; wr_en write strobe; addr shared read/write column;
//           wr_dat write data; rd_dat contents at addr before any write this cycle.
module window_line_buf
    import window_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int IMG_W = 640
) (
    input  logic                      clock,
    input  logic                      wr_en,
    input  logic [clog2(IMG_W)-1:0]   addr,
    input  logic [DSIZE-1:0]          wr_dat,
    output logic [DSIZE-1:0]          rd_dat
);

    // Not reset so it can map onto RAM; stale contents are masked by the
    // valid logic in the parent.
    logic [DSIZE-1:0] mem_q [IMG_W];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[addr];

endmodule

// File: rtl/window_5x5_gen.sv
// Purpose : streaming 5x5 neighbourhood generator feeding the 25-input median sorter.
// Latency : 1 cycle from accepted pixel to out_valid and its window.
// Backpressure: none; accepts a pixel every cycle in_valid is high.
// Ports   : clock, rst (async, active-high); in_valid/in_data raster pixel stream;
//           in_sof frame restart (only when WINDOW_SOF_EN is defined);
//           out_valid one-cycle strobe; od00..od24 window, row-major, od00 top-left,
//           od24 newest pixel, od12 centre.
// Build option: define WINDOW_SOF_EN to add the in_sof port.
module window_5x5_gen
    import window_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
`ifdef WINDOW_SOF_EN
    input  logic             in_sof,
`endif
    output logic             out_valid,
    output logic [DSIZE-1:0] od00, od01, od02, od03, od04,
    output logic [DSIZE-1:0] od05, od06, od07, od08, od09,
    output logic [DSIZE-1:0] od10, od11, od12, od13, od14,
    output logic [DSIZE-1:0] od15, od16, od17, od18, od19,
    output logic [DSIZE-1:0] od20, od21, od22, od23, od24
);

    localparam int CW = clog2(IMG_W);
    localparam int RW = clog2(IMG_H);
    localparam int NW = WIN_DIM * WIN_DIM;

    logic [CW-1:0] col_q, col_d, eff_col;
    logic [RW-1:0] row_q, row_d, eff_row;
    logic          out_valid_q, out_valid_d;
    logic [NW-1:0][DSIZE-1:0] win_q, win_d;
    logic [DSIZE-1:0] lb_rd   [WIN_LINES];
    logic [DSIZE-1:0] col_vec [WIN_DIM];
    logic          sof_hit;

`ifdef WINDOW_SOF_EN
    assign sof_hit = in_valid && in_sof;
`else
    assign sof_hit = 1'b0;
`endif

    // Position of the pixel being accepted; a start-of-frame forces (0,0).
    assign eff_col = sof_hit ? '0 : col_q;
    assign eff_row = sof_hit ? '0 : row_q;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_valid_d = (eff_row >= RW'(WIN_LINES)) && (eff_col >= CW'(WIN_LINES));
            if (eff_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
        end
    end

    // Cascade: each buffer takes the value the previous one held at this
    // column, so buffer k holds line row-1-k.
    for (genvar k = 0; k < WIN_LINES; k++) begin : g_lb
        logic [DSIZE-1:0] wr_dat;
        if (k == 0) begin : g_first
            assign wr_dat = in_data;
        end else begin : g_next
            assign wr_dat = lb_rd[k-1];
        end
        window_line_buf #(
            .DSIZE (DSIZE),
            .IMG_W (IMG_W)
        ) u_line_buf (
            .clock  (clock),
            .wr_en  (in_valid),
            .addr   (eff_col),
            .wr_dat (wr_dat),
            .rd_dat (lb_rd[k])
        );
    end

    // Column entering the right edge, top (oldest line) to bottom (current).
    always_comb begin
        for (int r = 0; r < WIN_LINES; r++) begin
            col_vec[r] = lb_rd[WIN_LINES-1-r];
        end
        col_vec[WIN_LINES] = in_data;
    end

    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    if (c < WIN_DIM - 1) begin
                        win_d[r*WIN_DIM+c] = win_q[r*WIN_DIM+c+1];
                    end else begin
                        win_d[r*WIN_DIM+c] = col_vec[r];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            win_q       <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            win_q       <= win_d;
        end
    end

    assign out_valid = out_valid_q;
    assign {od24, od23, od22, od21, od20, od19, od18, od17, od16, od15,
            od14, od13, od12, od11, od10, od09, od08, od07, od06, od05,
            od04, od03, od02, od01, od00} = win_q;

endmodule

// File: tb/tb_window_5x5_gen.sv
// Purpose : self-checking bench for window_5x5_gen with a frame-array reference model.
// Latency : expects each window one cycle after its qualifying accept.
// Backpressure: none; stimulus inserts random idle cycles instead.
module tb_window_5x5_gen;

    localparam int DSIZE = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;

    typedef logic [24:0][DSIZE-1:0] win_t;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [DSIZE-1:0] in_data = '0;
`ifdef WINDOW_SOF_EN
    logic             in_sof = 1'b0;
`endif
    logic             out_valid;
    logic [DSIZE-1:0] od00, od01, od02, od03, od04, od05, od06, od07, od08, od09,
                      od10, od11, od12, od13, od14, od15, od16, od17, od18, od19,
                      od20, od21, od22, od23, od24;
    win_t             dut_win;

    int   checks = 0;
    int   errors = 0;
    win_t exp_q[$];
    logic [DSIZE-1:0] pix [IMG_H][IMG_W];
    int   mr = 0;
    int   mc = 0;
    int   pulses = 0;
    win_t first_win = '0;
    win_t last_win = '0;

    always #5 clock = ~clock;

    window_5x5_gen #(
        .DSIZE (DSIZE),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef WINDOW_SOF_EN
        .in_sof    (in_sof),
`endif
        .out_valid (out_valid),
        .od00(od00), .od01(od01), .od02(od02), .od03(od03), .od04(od04),
        .od05(od05), .od06(od06), .od07(od07), .od08(od08), .od09(od09),
        .od10(od10), .od11(od11), .od12(od12), .od13(od13), .od14(od14),
        .od15(od15), .od16(od16), .od17(od17), .od18(od18), .od19(od19),
        .od20(od20), .od21(od21), .od22(od22), .od23(od23), .od24(od24)
    );

    assign dut_win = {od24, od23, od22, od21, od20, od19, od18, od17, od16, od15,
                      od14, od13, od12, od11, od10, od09, od08, od07, od06, od05,
                      od04, od03, od02, od01, od00};

    task automatic chk_eq(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference model: the frame is a 2-D array indexed by the pixel's raster
    // position; a window is simply the 5x5 block ending at that position.
    task automatic send_pix(input int gap_pct, input bit rnd, input bit sof);
        logic [DSIZE-1:0] d;
        win_t w;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
        end
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        d = rnd ? DSIZE'($urandom) : DSIZE'(mr * 16 + mc);
        pix[mr][mc] = d;
        if (mr >= 4 && mc >= 4) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    w[i*5+j] = pix[mr-4+i][mc-4+j];
                end
            end
            exp_q.push_back(w);
        end
        if (mc == IMG_W - 1) begin
            mc = 0;
            mr = (mr == IMG_H - 1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
        in_valid = 1'b1;
        in_data  = d;
`ifdef WINDOW_SOF_EN
        in_sof   = sof;
`endif
        @(posedge clock); #1;
        in_valid = 1'b0;
`ifdef WINDOW_SOF_EN
        in_sof   = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        mr = 0;
        mc = 0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        rst = 1'b0;
    endtask

    task automatic phase_check(input string tag, input int exp_pulses, input bit clean);
        repeat (3) begin
            @(posedge clock); #1;
        end
        chk_eq({tag, "_pulses"}, pulses, exp_pulses);
        chk_eq({tag, "_queue_left"}, exp_q.size(), 0);
        if (clean) begin
            chk_eq({tag, "_first_od00"}, first_win[0],  8'h00);
            chk_eq({tag, "_first_od04"}, first_win[4],  8'h04);
            chk_eq({tag, "_first_od12"}, first_win[12], 8'h22);
            chk_eq({tag, "_first_od20"}, first_win[20], 8'h40);
            chk_eq({tag, "_first_od24"}, first_win[24], 8'h44);
            chk_eq({tag, "_last_od00"},  last_win[0],   8'h13);
            chk_eq({tag, "_last_od24"},  last_win[24],  8'h57);
        end
        pulses = 0;
    endtask

    // Monitor: pops the scoreboard on every out_valid, checks reset state and
    // that outputs hold across cycles with no accept.
    initial begin : monitor
        bit   acc;
        bit   have_prev;
        win_t prev_win;
        win_t w;
        have_prev = 1'b0;
        prev_win  = '0;
        forever begin
            @(posedge clock);
            acc = in_valid && !rst;
            @(negedge clock);
            if (rst) begin
                chk_eq("reset_out_valid", out_valid, 1'b0);
                chk_eq("reset_window", dut_win, '0);
            end else if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got window %0h want no valid", dut_win);
                end else begin
                    w = exp_q.pop_front();
                    if (dut_win !== w) begin
                        errors++;
                        $display("FAIL window: got %0h want %0h", dut_win, w);
                    end
                    if (pulses == 0) first_win = dut_win;
                    last_win = dut_win;
                    pulses++;
                end
            end else if (!acc && have_prev) begin
                chk_eq("hold_window", dut_win, prev_win);
            end
            prev_win  = dut_win;
            have_prev = 1'b1;
        end
    end

    initial begin : stimulus
        repeat (2) begin
            @(posedge clock); #1;
        end
        rst = 1'b0;

        repeat (IMG_W * IMG_H) send_pix(0, 1'b0, 1'b0);
        phase_check("continuous", 8, 1'b1);

        repeat (IMG_W * IMG_H) send_pix(30, 1'b0, 1'b0);
        phase_check("gaps", 8, 1'b1);

        repeat (2 * IMG_W * IMG_H) send_pix(0, 1'b0, 1'b0);
        phase_check("two_frames", 16, 1'b0);

        repeat (2 * IMG_W * IMG_H) send_pix(30, 1'b1, 1'b0);
        phase_check("random_data", 16, 1'b0);

        // Reset right after pixel 0x33, then a clean frame; the first
        // accept is driven in the same cycle reset deasserts.
        repeat (28) send_pix(0, 1'b0, 1'b0);
        do_reset();
        repeat (IMG_W * IMG_H) send_pix(0, 1'b0, 1'b0);
        phase_check("after_reset", 8, 1'b1);

`ifdef WINDOW_SOF_EN
        repeat (19) send_pix(0, 1'b0, 1'b0);
        send_pix(0, 1'b0, 1'b1);
        repeat (IMG_W * IMG_H - 1) send_pix(0, 1'b0, 1'b0);
        phase_check("sof", 8, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
